mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/lc3b_types.sv | 17 +
 rtl/mem_arbiter_grant_logic.sv | 26 ++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b memory types and the state encoding for the two-port memory arbiter.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_A,
        BUSY_B,
        DONE_A,
        DONE_B
    } lc3b_arb_state;

    localparam lc3b_mem_wmask FULL_WORD_MASK = 2'b11;

endpackage

// File: rtl/mem_arbiter_grant_logic.sv
// Picks which port wins when the arbiter is idle.
// Build option ARB_ROUND_ROBIN_EN: contention alternates on a last-grant pointer
// instead of always favouring port B.
module arbiter_grant_logic (
    input  logic req_a,
    input  logic req_b,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_grant_b,
`endif
    output logic grant_valid,
    output logic grant_b
);

    always_comb begin
        grant_valid = req_a | req_b;
`ifdef ARB_ROUND_ROBIN_EN
        if (req_a && req_b)
            grant_b = ~last_grant_b;
        else
            grant_b = req_b;
`else
        grant_b = req_b;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch A, data B) arbiter onto one downstream memory, one access in flight.
// Build option ARB_ROUND_ROBIN_EN selects round-robin instead of fixed port-B priority.
//
// state  | meaning
// IDLE   | waiting for a request; latches the winner's address/data/mask/op
// BUSY_A | downstream read on behalf of port A
// BUSY_B | downstream read or write on behalf of port B
// DONE_A | one-cycle resp_a (suppressed if port A dropped its request)
// DONE_B | one-cycle resp_b (suppressed if port B dropped its request)
module mem_arbiter
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          rst,

    input  lc3b_word      mem_addr1,
    input  logic          mem_read1,
    output lc3b_word      mem_rdata1,
    output logic          resp_a,

    input  lc3b_word      mem_addr2,
    input  logic          mem_read2,
    input  logic          mem_write2,
    input  lc3b_word      mem_wdata2,
    input  lc3b_mem_wmask mem_byte_enable2,
    output lc3b_word      mem_rdata2,
    output logic          resp_b,

    output lc3b_word      pmem_address,
    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_word      pmem_wdata,
    output lc3b_mem_wmask pmem_byte_enable,
    input  lc3b_word      pmem_rdata,
    input  logic          pmem_resp
);

    lc3b_arb_state state_q, state_d;

    lc3b_word      addr_q;
    lc3b_word      wdata_q;
    lc3b_mem_wmask mask_q;
    logic          write_q;
    lc3b_word      rdata1_q;
    lc3b_word      rdata2_q;

    logic          req_b;
    logic          grant_valid;
    logic          grant_b;

    assign req_b = mem_read2 | mem_write2;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_b_q;

    arbiter_grant_logic u_grant (
        .req_a        (mem_read1),
        .req_b        (req_b),
        .last_grant_b (last_grant_b_q),
        .grant_valid  (grant_valid),
        .grant_b      (grant_b)
    );
`else
    arbiter_grant_logic u_grant (
        .req_a       (mem_read1),
        .req_b       (req_b),
        .grant_valid (grant_valid),
        .grant_b     (grant_b)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            write_q  <= 1'b0;
            rdata1_q <= '0;
            rdata2_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_b_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && grant_valid) begin
                if (grant_b) begin
                    addr_q  <= mem_addr2;
                    wdata_q <= mem_wdata2;
                    mask_q  <= mem_byte_enable2;
                    write_q <= mem_write2;
                end else begin
                    addr_q  <= mem_addr1;
                    wdata_q <= '0;
                    mask_q  <= FULL_WORD_MASK;
                    write_q <= 1'b0;
                end
`ifdef ARB_ROUND_ROBIN_EN
                last_grant_b_q <= grant_b;
`endif
            end
            // Read data is captured on completion even if the requester has since gone away.
            if (state_q == BUSY_A && pmem_resp)
                rdata1_q <= pmem_rdata;
            if (state_q == BUSY_B && pmem_resp && !write_q)
                rdata2_q <= pmem_rdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        resp_a     = 1'b0;
        resp_b     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_valid)
                    state_d = grant_b ? BUSY_B : BUSY_A;
            end
            BUSY_A: begin
                pmem_read = 1'b1;
                if (pmem_resp)
                    state_d = DONE_A;
            end
            BUSY_B: begin
                pmem_read  = ~write_q;
                pmem_write = write_q;
                if (pmem_resp)
                    state_d = DONE_B;
            end
            DONE_A: begin
                resp_a  = mem_read1;
                state_d = IDLE;
            end
            DONE_B: begin
                resp_b  = req_b;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pmem_address     = addr_q;
    assign pmem_wdata       = wdata_q;
    assign pmem_byte_enable = mask_q;
    assign mem_rdata1       = rdata1_q;
    assign mem_rdata2       = rdata2_q;

endmodule
